// File: rtl/stage4_msg_assemble_pkg.sv
// Shared definitions for the stage-4 message assembler.
// Holds the message image size, the lane type-code encoding, the
// default stream/flush parameters, the receive FSM state type and the
// type-byte decode helper.
package stage4_msg_assemble_pkg;

  localparam int unsigned MAX_MESSAGE_BITS          = 512;
  localparam int unsigned MESSAGE_MUX_CONTROL_WIDTH = 2;
  localparam int unsigned DATA_W_DEF                = 64;
  localparam int unsigned FLUSH_CYCLES_DEF          = 16;

  typedef logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] mux_ctrl_t;

  localparam mux_ctrl_t MESSAGE_MUX_NONE  = 2'd0;
  localparam mux_ctrl_t MESSAGE_MUX_K     = 2'd1;
  localparam mux_ctrl_t MESSAGE_MUX_OTHER = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } rx_state_t;

  function automatic mux_ctrl_t decode_type(input logic [7:0] type_byte,
                                            input logic [7:0] type_k);
    return (type_byte == type_k) ? MESSAGE_MUX_K : MESSAGE_MUX_OTHER;
  endfunction

endpackage

// File: rtl/stage4_word_pack_module.sv
// Message assembly buffer for stage 4.
// Packs stream words left-aligned into a MAX_MESSAGE_BITS image, zeroes
// the trailing empty bytes of the eop word and flags words that no longer
// fit. o_image is the image including the current word, so a message
// completing this cycle can be captured directly.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : write current word at index 0 into a cleared buffer
//   i_append    : write current word at the next index
//   i_eop       : current word is the last one (enables empty masking)
//   i_data      : stream word, byte 0 in the MSBs
//   i_empty     : invalid trailing bytes of the eop word
//   o_image     : buffer image after this cycle's write
//   o_overflow  : pulse, a written word was dropped for lack of space
module stage4_word_pack_module
  import stage4_msg_assemble_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_append,
  input  logic                        i_eop,
  input  logic [DATA_W-1:0]           i_data,
  input  logic [2:0]                  i_empty,
  output logic [MAX_MESSAGE_BITS-1:0] o_image,
  output logic                        o_overflow
);

  localparam int unsigned WORDS = MAX_MESSAGE_BITS / DATA_W;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(WORDS + 1);

  logic [MAX_MESSAGE_BITS-1:0] r_buf;
  logic [IDX_W-1:0]            r_idx;
  logic [DATA_W-1:0]           w_word;
  logic [IDX_W-1:0]            w_base_idx;
  logic [MAX_MESSAGE_BITS-1:0] w_base_buf;
  logic                        w_fit;
  logic                        w_write;

  always_comb begin
    w_word = i_data;
    if (i_eop) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (b + 32'(i_empty) >= BYTES) begin
          w_word[DATA_W-1-b*8 -: 8] = '0;
        end
      end
    end
    w_write    = i_start | i_append;
    w_base_idx = i_start ? '0 : r_idx;
    w_base_buf = i_start ? '0 : r_buf;
    w_fit      = (w_base_idx < IDX_W'(WORDS));
    o_image    = w_base_buf;
    if (w_fit) begin
      o_image[MAX_MESSAGE_BITS-1-32'(w_base_idx)*DATA_W -: DATA_W] = w_word;
    end
    o_overflow = w_write & ~w_fit;
  end

  // Index saturates at WORDS so every later word of an oversized
  // message keeps reporting overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_idx <= '0;
    end else if (w_write) begin
      r_buf <= o_image;
      r_idx <= w_fit ? w_base_idx + 1'b1 : w_base_idx;
    end
  end

endmodule

// File: rtl/stage4_msg_assemble_module.sv
// Stage-4 message assembler: receives the 64-bit market-data word stream,
// assembles messages and issues them to stage 5 in batches of up to three
// lanes. A batch issues when lane 3 fills or when a partial batch has
// seen no completion for FLUSH_CYCLES cycles.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_data/valid/sop/eop     : input stream word and framing
//   in_empty                  : invalid trailing bytes in the eop word
//   message_en                : one-cycle batch strobe
//   message_1/2/3             : lane images, message byte 0 at the MSB
//   message_mux_control_m1/2/3: lane type codes
//   err_overflow              : sticky, a message exceeded the image size
//   err_protocol              : sticky, framing violation seen
module stage4_msg_assemble_module
  import stage4_msg_assemble_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter logic [7:0]  TYPE_K       = 8'h6B
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic                                 in_valid,
  input  logic                                 in_sop,
  input  logic                                 in_eop,
  input  logic [2:0]                           in_empty,
  output logic                                 message_en,
  output logic [MAX_MESSAGE_BITS-1:0]          message_1,
  output logic [MAX_MESSAGE_BITS-1:0]          message_2,
  output logic [MAX_MESSAGE_BITS-1:0]          message_3,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m1,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m2,
  output logic [MESSAGE_MUX_CONTROL_WIDTH-1:0] message_mux_control_m3,
  output logic                                 err_overflow,
  output logic                                 err_protocol
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  rx_state_t                   r_state;
  rx_state_t                   w_state_next;
  logic                        w_start;
  logic                        w_append;
  logic                        w_drop;
  logic                        w_done;
  logic                        w_issue;
  logic                        w_ovf;
  logic [MAX_MESSAGE_BITS-1:0] w_image;
  logic [MAX_MESSAGE_BITS-1:0] r_lane_msg [3];
  logic [MAX_MESSAGE_BITS-1:0] w_lane_msg [3];
  mux_ctrl_t                   r_lane_ctl [3];
  mux_ctrl_t                   w_lane_ctl [3];
  logic [1:0]                  r_fill;
  logic [1:0]                  w_fill;
  logic [FLUSH_W-1:0]          r_flush;

  stage4_word_pack_module #(
    .DATA_W(DATA_W)
  ) u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_append  (w_append),
    .i_eop     (in_eop),
    .i_data    (in_data),
    .i_empty   (in_empty),
    .o_image   (w_image),
    .o_overflow(w_ovf)
  );

  always_comb begin
    // sop restarts assembly in either state; in BODY it also abandons
    // the partial message.
    w_start  = in_valid & in_sop;
    w_append = in_valid & ~in_sop & (r_state == ST_BODY);
    w_drop   = in_valid & ~in_sop & (r_state == ST_IDLE);
    w_done   = (w_start | w_append) & in_eop;

    w_state_next = r_state;
    if (w_start) begin
      w_state_next = in_eop ? ST_IDLE : ST_BODY;
    end else if (w_append && in_eop) begin
      w_state_next = ST_IDLE;
    end

    // Staging as it will look with this cycle's completion included, so a
    // third-lane fill issues on the same edge it is captured.
    w_lane_msg = r_lane_msg;
    w_lane_ctl = r_lane_ctl;
    w_fill     = r_fill;
    if (w_done) begin
      w_lane_msg[r_fill] = w_image;
      w_lane_ctl[r_fill] = decode_type(w_image[MAX_MESSAGE_BITS-1 -: 8], TYPE_K);
      w_fill             = r_fill + 2'd1;
    end

    // A completion always restarts the flush wait, so expiry only issues
    // in a cycle without one.
    if (w_done) begin
      w_issue = (r_fill == 2'd2);
    end else begin
      w_issue = (r_fill != 2'd0) && (r_flush == FLUSH_W'(FLUSH_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                <= ST_IDLE;
      r_fill                 <= '0;
      r_flush                <= '0;
      message_en             <= 1'b0;
      message_1              <= '0;
      message_2              <= '0;
      message_3              <= '0;
      message_mux_control_m1 <= MESSAGE_MUX_NONE;
      message_mux_control_m2 <= MESSAGE_MUX_NONE;
      message_mux_control_m3 <= MESSAGE_MUX_NONE;
      err_overflow           <= 1'b0;
      err_protocol           <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_lane_msg[i] <= '0;
        r_lane_ctl[i] <= MESSAGE_MUX_NONE;
      end
    end else begin
      r_state    <= w_state_next;
      message_en <= w_issue;
      if (w_ovf) begin
        err_overflow <= 1'b1;
      end
      if ((w_start && r_state == ST_BODY) || w_drop) begin
        err_protocol <= 1'b1;
      end
      if (w_issue) begin
        message_1              <= w_lane_msg[0];
        message_2              <= w_lane_msg[1];
        message_3              <= w_lane_msg[2];
        message_mux_control_m1 <= w_lane_ctl[0];
        message_mux_control_m2 <= w_lane_ctl[1];
        message_mux_control_m3 <= w_lane_ctl[2];
        r_fill                 <= '0;
        r_flush                <= '0;
        for (int unsigned i = 0; i < 3; i++) begin
          r_lane_msg[i] <= '0;
          r_lane_ctl[i] <= MESSAGE_MUX_NONE;
        end
      end else begin
        r_lane_msg <= w_lane_msg;
        r_lane_ctl <= w_lane_ctl;
        r_fill     <= w_fill;
        if (w_done || r_fill == 2'd0) begin
          r_flush <= '0;
        end else begin
          r_flush <= r_flush + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage4_msg_assemble_module.sv
// Self-checking bench for stage4_msg_assemble_module. Completed messages
// are rebuilt from the driven bytes, grouped into batches by arrival time
// and compared with the batches observed on message_en.
module tb_stage4_msg_assemble_module;
  import stage4_msg_assemble_pkg::*;

  localparam int unsigned MAXB  = MAX_MESSAGE_BITS;
  localparam int          FLUSH = 16;
  localparam int          INF   = 32'h7fff_ffff;

  typedef struct {
    logic [MAXB-1:0] img;
    logic [1:0]      ctl;
    int              t;
  } msg_t;

  typedef struct {
    int              t;
    logic [MAXB-1:0] m1, m2, m3;
    logic [1:0]      c1, c2, c3;
  } batch_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [63:0]     in_data = '0;
  logic            in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]      in_empty = '0;
  logic            message_en;
  logic [MAXB-1:0] message_1, message_2, message_3;
  logic [1:0]      message_mux_control_m1, message_mux_control_m2, message_mux_control_m3;
  logic            err_overflow, err_protocol;

  stage4_msg_assemble_module #(
    .DATA_W(64),
    .FLUSH_CYCLES(16),
    .TYPE_K(8'h6B)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty),
    .message_en(message_en),
    .message_1(message_1), .message_2(message_2), .message_3(message_3),
    .message_mux_control_m1(message_mux_control_m1),
    .message_mux_control_m2(message_mux_control_m2),
    .message_mux_control_m3(message_mux_control_m3),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  msg_t       done_q[$];
  batch_t     obs_q[$];
  batch_t     exp_q[$];
  batch_t     last_batch;
  logic [7:0] cur_bytes[$];
  int         cur_words = 0;
  bit         in_msg = 0;
  bit         exp_ovf = 0;
  bit         exp_prot = 0;

  task automatic check_eq(input string tag, input logic [MAXB-1:0] obs, input logic [MAXB-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void clear_batch(output batch_t b);
    b.t  = 0;
    b.m1 = '0; b.m2 = '0; b.m3 = '0;
    b.c1 = MESSAGE_MUX_NONE; b.c2 = MESSAGE_MUX_NONE; b.c3 = MESSAGE_MUX_NONE;
  endfunction

  function automatic void set_lane(inout batch_t b, input int n, input msg_t m);
    case (n)
      0: begin b.m1 = m.img; b.c1 = m.ctl; end
      1: begin b.m2 = m.img; b.c2 = m.ctl; end
      2: begin b.m3 = m.img; b.c3 = m.ctl; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    batch_t b;
    if (rst_n && message_en) begin
      b.t  = cyc;
      b.m1 = message_1; b.m2 = message_2; b.m3 = message_3;
      b.c1 = message_mux_control_m1;
      b.c2 = message_mux_control_m2;
      b.c3 = message_mux_control_m3;
      obs_q.push_back(b);
    end
  end

  // Reference: a message is the byte sequence of its words (first 64 bytes
  // kept, empty eop bytes zero), left-aligned in the image.
  task automatic model_word(input bit v, input bit s, input bit e,
                            input logic [2:0] emp, input logic [63:0] d);
    msg_t            m;
    logic [MAXB-1:0] img;
    if (!v) return;
    if (s) begin
      if (in_msg) exp_prot = 1;
      in_msg = 1;
      cur_bytes.delete();
      cur_words = 0;
    end else if (!in_msg) begin
      exp_prot = 1;
      return;
    end
    if (cur_words < int'(MAXB / 64)) begin
      for (int j = 0; j < 8; j++) begin
        logic [7:0] bb;
        bb = d[63-8*j -: 8];
        if (e && j >= 8 - int'(emp)) bb = '0;
        cur_bytes.push_back(bb);
      end
    end else begin
      exp_ovf = 1;
    end
    cur_words++;
    if (e) begin
      img = '0;
      foreach (cur_bytes[i]) img = {img[MAXB-9:0], cur_bytes[i]};
      img = img << (8 * (int'(MAXB / 8) - cur_bytes.size()));
      m.img = img;
      m.ctl = (cur_bytes[0] == 8'h6B) ? MESSAGE_MUX_K : MESSAGE_MUX_OTHER;
      m.t   = cyc;
      done_q.push_back(m);
      in_msg = 0;
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit e,
                       input logic [2:0] emp, input logic [63:0] d);
    in_valid = v; in_sop = s; in_eop = e; in_empty = emp; in_data = d;
    @(posedge clk);
    #1;
    model_word(v, s, e, emp, d);
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input int nw, input logic [7:0] b0, input logic [2:0] emp, input bit gaps);
    logic [63:0] d;
    for (int w = 0; w < nw; w++) begin
      d = {$urandom, $urandom};
      if (w == 0) d[63:56] = b0;
      drive(1'b1, w == 0, w == nw - 1, (w == nw - 1) ? emp : 3'd0, d);
      if (gaps && w < nw - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic check_outs(input string tag, input batch_t b);
    check_eq({tag, "_m1"},   message_1, b.m1);
    check_eq({tag, "_m2"},   message_2, b.m2);
    check_eq({tag, "_m3"},   message_3, b.m3);
    check_eq({tag, "_ctl1"}, message_mux_control_m1, b.c1);
    check_eq({tag, "_ctl2"}, message_mux_control_m2, b.c2);
    check_eq({tag, "_ctl3"}, message_mux_control_m3, b.c3);
  endtask

  // Batching by time: a message joins the open batch if it completes
  // within FLUSH cycles of the previous completion; a full batch issues
  // with its third message, otherwise FLUSH cycles after the last one.
  task automatic close_segment(input int cutoff, input bit was_reset);
    batch_t cur;
    int     n, last;
    exp_q.delete();
    clear_batch(cur);
    n = 0;
    last = 0;
    foreach (done_q[i]) begin
      if (n > 0 && done_q[i].t - last > FLUSH) begin
        cur.t = last + FLUSH;
        if (cur.t < cutoff) exp_q.push_back(cur);
        clear_batch(cur);
        n = 0;
      end
      set_lane(cur, n, done_q[i]);
      n++;
      last = done_q[i].t;
      if (n == 3) begin
        cur.t = last;
        if (cur.t < cutoff) exp_q.push_back(cur);
        clear_batch(cur);
        n = 0;
      end
    end
    if (n > 0) begin
      cur.t = last + FLUSH;
      if (cur.t < cutoff) exp_q.push_back(cur);
    end
    check_eq("batch_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq($sformatf("b%0d_cycle", i), obs_q[i].t, exp_q[i].t);
      check_eq($sformatf("b%0d_m1", i), obs_q[i].m1, exp_q[i].m1);
      check_eq($sformatf("b%0d_m2", i), obs_q[i].m2, exp_q[i].m2);
      check_eq($sformatf("b%0d_m3", i), obs_q[i].m3, exp_q[i].m3);
      check_eq($sformatf("b%0d_ctl1", i), obs_q[i].c1, exp_q[i].c1);
      check_eq($sformatf("b%0d_ctl2", i), obs_q[i].c2, exp_q[i].c2);
      check_eq($sformatf("b%0d_ctl3", i), obs_q[i].c3, exp_q[i].c3);
    end
    if (exp_q.size() > 0) last_batch = exp_q[exp_q.size() - 1];
    if (was_reset) clear_batch(last_batch);
    check_outs(was_reset ? "reset_out" : "hold", last_batch);
    check_eq("message_en_low", message_en, 1'b0);
    check_eq("err_overflow", err_overflow, exp_ovf);
    check_eq("err_protocol", err_protocol, exp_prot);
    done_q.delete();
    obs_q.delete();
  endtask

  task automatic reset_mid();
    int cut;
    @(negedge clk);
    #1;
    cut = cyc + 1;
    rst_n = 0;
    #1;
    in_msg = 0;
    cur_bytes.delete();
    cur_words = 0;
    exp_ovf = 0;
    exp_prot = 0;
    close_segment(cut, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    clear_batch(last_batch);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", last_batch);
    check_eq("reset_en", message_en, 1'b0);
    check_eq("reset_ovf", err_overflow, 1'b0);
    check_eq("reset_prot", err_protocol, 1'b0);
    rst_n = 1;
    idle(2);

    // Back-to-back single-word messages: 6B/41/6B fill a batch, a fourth
    // lands in a fresh lane 1 and flushes alone.
    send_msg(1, 8'h6B, 3'd0, 0);
    send_msg(1, 8'h41, 3'd0, 0);
    send_msg(1, 8'h6B, 3'd0, 0);
    send_msg(1, 8'h41, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Partial batch flushes after the idle window.
    send_msg(2, 8'h6B, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Flush boundary: 16 cycles apart joins, 17 apart splits.
    send_msg(1, 8'h11, 3'd0, 0);
    idle(15);
    send_msg(1, 8'h6B, 3'd0, 0);
    idle(16);
    send_msg(1, 8'h22, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Oversized message truncated to 8 words.
    send_msg(9, 8'h6B, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // sop mid-message abandons the first message.
    drive(1'b1, 1'b1, 1'b0, 3'd0, {8'h41, 24'h0, $urandom});
    drive(1'b1, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    send_msg(2, 8'h6B, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Empty-byte masking.
    send_msg(1, 8'h6B, 3'd3, 0);
    send_msg(2, 8'h41, 3'd7, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Reset with lane 2 filled and a message mid-body.
    send_msg(1, 8'h6B, 3'd0, 0);
    send_msg(1, 8'h41, 3'd0, 0);
    drive(1'b1, 1'b1, 1'b0, 3'd0, {$urandom, $urandom});
    drive(1'b1, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    reset_mid();
    send_msg(1, 8'h6B, 3'd0, 0);
    send_msg(2, 8'h41, 3'd1, 0);
    send_msg(1, 8'h6B, 3'd0, 0);
    idle(20);
    close_segment(INF, 1'b0);

    // Random traffic.
    for (int k = 0; k < 180; k++) begin
      int nw, gap;
      nw  = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 11) : $urandom_range(1, 4);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 6);
      if ($urandom_range(0, 19) == 0) drive(1'b1, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
      send_msg(nw, ($urandom_range(0, 1) == 1) ? 8'h6B : 8'($urandom),
               3'($urandom_range(0, 7)), 1'b1);
      idle(gap);
      if (k % 30 == 29) begin
        idle(20);
        close_segment(INF, 1'b0);
      end
    end
    idle(20);
    close_segment(INF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4_msg_assemble_module.md
Name: stage4_msg_assemble_module

Overview:
- Upstream neighbour of the stage-5 field extractors: packs the incoming 64-bit market-data word stream into three parallel message lanes for stage 5.
- Each lane carries one left-aligned message image of `MAX_MESSAGE_BITS, a decoded type code, and a shared one-cycle message_en strobe.
- Messages are packed into lanes 1, 2, 3 in arrival order. A batch issues when lane 3 fills, or when a partial batch has waited FLUSH_CYCLES.

Parameters:
- DATA_W, 64, input word width in bits (multiple of 8)
- FLUSH_CYCLES, 16, idle cycles after the last lane fill before a partial batch issues
- TYPE_K, 8'h6B, type byte that decodes to `message_mux_k

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DATA_W  stream word; byte 0 is in_data[DATA_W-1:DATA_W-8]
- in_valid  in  1  word qualifier
- in_sop  in  1  first word of a message
- in_eop  in  1  last word of a message
- in_empty  in  3  invalid trailing bytes in the eop word
- message_en  out  1  one-cycle batch strobe
- message_1/2/3  out  `MAX_MESSAGE_BITS  lane images; message byte 0 at the MSB
- message_mux_control_m1/m2/m3  out  `message_mux_control_width  lane type code
- err_overflow  out  1  sticky: a message exceeded `MAX_MESSAGE_BITS
- err_protocol  out  1  sticky: sop while mid-message, or a word without sop while idle

Behaviour:
- Reset (async, rst_n=0):
  - message_en=0.
  - All message_* outputs and staging lanes = 0.
  - All mux controls = `message_mux_none.
  - Both error flags = 0.
  - FSM state = IDLE; word index, fill count and flush counter = 0.
- Receive FSM, states IDLE and BODY:
  - IDLE + valid&sop: clear the assembly buffer, write the word at index 0, then go to BODY. If eop is also set, complete the message in the same cycle and stay in IDLE.
  - IDLE + valid&!sop: drop the word and set err_protocol.
  - BODY + valid: write the word at the next index. On eop, complete the message and go to IDLE.
  - BODY + valid&sop: discard the partial message, set err_protocol, and restart at index 0 with the new word.
  - in_valid=0 holds state.
- Buffer write: word index k goes to bits [MAX-1-k*DATA_W -: DATA_W].
  - Index beyond MAX/DATA_W-1: word dropped, err_overflow set. The message still completes at eop, truncated.
  - Bytes flagged by in_empty are written as 0.
- Type decode: byte 0 == TYPE_K gives `message_mux_k; any other value gives `message_mux_other.
- Message completion:
  - The image and type go into staging lane fill_count+1, and fill_count increments.
  - The flush counter reloads to 0.
- Issue condition: fill_count reaches 3, or fill_count>0 and the flush counter reaches FLUSH_CYCLES-1.
- On issue, next cycle:
  - message_en=1 for exactly one cycle.
  - Lanes are copied to the outputs; unfilled lanes drive 0 with `message_mux_none.
  - Staging and fill_count clear.
- Outputs hold their values between issues.
- Latency: the eop that fills lane 3 at cycle N gives message_en at N+1.
- Flush counter:
  - Increments while 0<fill_count<3 and no completion occurs.
  - Frozen at 0 when fill_count=0.
- Simultaneous events:
  - Completion in the flush-expiry cycle: the message joins the batch. If it makes the third lane, one issue with 3 lanes; otherwise the counter reloads and there is no issue.
  - A completion in the cycle after an issue lands in the fresh lane 1. No stall and no in_ready.
- Reset mid-message or mid-batch discards everything. No message_en fires for discarded data.

Decomposition:
- para_def.v additions: `message_mux_none, `message_mux_other, `DATA_W_DEF, `FLUSH_CYCLES_DEF. The existing `message_mux_k and `MAX_MESSAGE_BITS are reused.
- One sub-module, stage4_word_pack_module: the assembly buffer, word index, empty-byte masking and overflow detect.
- The top level holds the FSM, lane staging, flush counter and issue logic.

Test Plan:
- Three back-to-back single-word messages, types 6B/41/6B → message_en one cycle after the third eop; controls k/other/k; message_1 top 64 bits = first word; lower bits 0.
- One 2-word type-6B message, then idle 16 cycles → message_en at eop+17; lane1 = k; lanes 2/3 = none and 0.
- A 9-word message with MAX=512 → err_overflow=1; lane holds the first 8 words; completes at eop.
- sop mid-message → err_protocol=1; the first message is never issued; the second message lands in lane 1.
- eop word with in_empty=3 → the last 3 bytes of the lane word are 0.
- rst_n low while lane 2 is filled and a message is mid-body → all outputs 0; after release, the next 3 messages issue normally.
